// File: rtl/prbs6_checker.sv
// prbs6_checker: self-synchronising PRBS6 (x^6+x^5+1) checker.
// The checker hunts for a non-zero seed word and verifies a run of correct
// successors before it declares lock. Once locked it flywheels its own
// reference through errors and counts mismatches in a saturating counter.
// Optional macro PRBS6_CHECKER_LOSS_CNT_EN adds loss_cnt_o, a saturating
// count of LOCKED->HUNT transitions.
module prbs6_checker #(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int ERR_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic [5:0]       data_i,
   input  logic             clr_i,
   output logic             locked_o,
   output logic             err_o,
`ifdef PRBS6_CHECKER_LOSS_CNT_EN
   output logic [7:0]       loss_cnt_o,
`endif
   output logic [ERR_W-1:0] err_cnt_o
);

   localparam int MATCH_W = $clog2(LOCK_CNT + 1);
   localparam int MISS_W  = $clog2(LOSS_CNT + 1);
   localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);
   localparam logic [MISS_W-1:0]  LOSS_TGT = MISS_W'(LOSS_CNT);

   typedef enum logic [1:0] {
      HUNT   = 2'b00,
      VERIFY = 2'b01,
      LOCKED = 2'b10
   } state_t;

   state_t             state;
   logic [5:0]         ref_word;
   logic [MATCH_W-1:0] match_cnt;
   logic [MISS_W-1:0]  miss_cnt;

   logic               is_match;
   logic               is_zero;
   logic               err_hit;
   logic               loss_hit;
   logic [MATCH_W-1:0] match_next;
   logic [MISS_W-1:0]  miss_next;

   // One step of the Fibonacci left-shift LFSR.
   function automatic logic [5:0] prbs_next(input logic [5:0] x);
      return {x[4:0], x[5] ^ x[4]};
   endfunction

   assign is_match   = (data_i == ref_word);
   assign is_zero    = (data_i == 6'h00);
   assign match_next = match_cnt + MATCH_W'(1);
   assign miss_next  = miss_cnt + MISS_W'(1);
   assign err_hit    = en_i && (state == LOCKED) && !is_match;
   assign loss_hit   = err_hit && (miss_next == LOSS_TGT);

   // Hunt/verify/lock sequencing, reference regeneration and lock flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= HUNT;
         ref_word  <= 6'h00;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked_o  <= 1'b0;
      end else begin
         case (state)
            HUNT: begin
               if (en_i && !is_zero) begin
                  ref_word  <= prbs_next(data_i);
                  match_cnt <= '0;
                  state     <= VERIFY;
               end
            end
            VERIFY: begin
               if (en_i) begin
                  if (is_match) begin
                     ref_word  <= prbs_next(data_i);
                     match_cnt <= match_next;
                     if (match_next == LOCK_TGT) begin
                        state    <= LOCKED;
                        miss_cnt <= '0;
                        locked_o <= 1'b1;
                     end
                  end else if (!is_zero) begin
                     ref_word  <= prbs_next(data_i);
                     match_cnt <= '0;
                  end else begin
                     state <= HUNT;
                  end
               end
            end
            LOCKED: begin
               if (en_i) begin
                  ref_word <= prbs_next(ref_word);
                  if (is_match) begin
                     miss_cnt <= '0;
                  end else begin
                     miss_cnt <= miss_next;
                     if (loss_hit) begin
                        state    <= HUNT;
                        locked_o <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state    <= HUNT;
               locked_o <= 1'b0;
            end
         endcase
      end
   end

   // Single-cycle error pulse for each mismatch seen while locked.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_o <= 1'b0;
      end else begin
         err_o <= err_hit;
      end
   end

   // Saturating error count; a clear wins over a coincident error.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         err_cnt_o <= '0;
      end else if (err_hit && (err_cnt_o != '1)) begin
         err_cnt_o <= err_cnt_o + ERR_W'(1);
      end
   end

`ifdef PRBS6_CHECKER_LOSS_CNT_EN
   // Saturating count of lock losses, cleared with the same priority.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         loss_cnt_o <= 8'h00;
      end else if (loss_hit && (loss_cnt_o != 8'hFF)) begin
         loss_cnt_o <= loss_cnt_o + 8'h01;
      end
   end
`endif

endmodule
